// File: rtl/sram_b_arb_pkg.sv
// Shared types and helpers for the SRAM B-port sequencer/arbiter.
// Holds the state encoding and a one-hot to index conversion.
package sram_b_arb_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

    localparam int MAX_REQ = 8;

    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps,
// producing a one-hot grant plus the winner's index.
module rr_arbiter_onehot
    import sram_b_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int  cand;
        logic found;
        cand  = 0;
        found = 1'b0;
        gnt   = '0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
            end
        end
    end

    assign idx = IW'(onehot_to_idx(MAX_REQ'(gnt)));
    assign any = |req;

endmodule

// File: rtl/sram_b_port_arbiter.sv
// Zero-fills a 1w:1r SRAM after reset, then round-robin shares its write and
// read ports among NREQ clients, holding back reads that collide with a write.
module sram_b_port_arbiter
    import sram_b_arb_pkg::*;
#(
    parameter int ABITS   = 10,
    parameter int DBITS   = 8,
    parameter int NREQ    = 2,
    parameter int INIT_EN = 1
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic [NREQ-1:0]       wr_req,
    input  logic [NREQ*ABITS-1:0] wr_addr,
    input  logic [NREQ*DBITS-1:0] wr_data,
    input  logic [NREQ*DBITS-1:0] wr_wem,
    output logic [NREQ-1:0]       wr_gnt,
    input  logic [NREQ-1:0]       rd_req,
    input  logic [NREQ*ABITS-1:0] rd_addr,
    output logic [NREQ-1:0]       rd_gnt,
    output logic [NREQ-1:0]       rd_valid,
    output logic [DBITS-1:0]      rd_data,
    output logic                  init_done,
    output logic                  mem_ce0,
    output logic                  mem_we0,
    output logic [ABITS-1:0]      mem_a0,
    output logic [DBITS-1:0]      mem_d0,
    output logic [DBITS-1:0]      mem_wem0,
    output logic                  mem_ce1,
    output logic [ABITS-1:0]      mem_a1,
    input  logic [DBITS-1:0]      mem_q1
);

    localparam int IW = $clog2(NREQ);

    arb_state_t        state_q, state_d;
    logic [ABITS-1:0]  init_cnt;
    logic [IW-1:0]     wr_ptr, rd_ptr;
    logic [NREQ-1:0]   wr_arb_gnt, rd_arb_gnt;
    logic [IW-1:0]     wr_win, rd_win;
    logic              wr_any, rd_any;
    logic [ABITS-1:0]  wr_addr_sel, rd_addr_sel;
    logic              hazard;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] win);
        return (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
    endfunction

    rr_arbiter_onehot #(.N(NREQ), .IW(IW)) u_wr_arb (
        .req (wr_req),
        .ptr (wr_ptr),
        .gnt (wr_arb_gnt),
        .idx (wr_win),
        .any (wr_any)
    );

    rr_arbiter_onehot #(.N(NREQ), .IW(IW)) u_rd_arb (
        .req (rd_req),
        .ptr (rd_ptr),
        .gnt (rd_arb_gnt),
        .idx (rd_win),
        .any (rd_any)
    );

    assign wr_addr_sel = wr_addr[int'(wr_win)*ABITS +: ABITS];
    assign rd_addr_sel = rd_addr[int'(rd_win)*ABITS +: ABITS];
    assign hazard      = wr_any && (rd_addr_sel == wr_addr_sel);

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q  <= (INIT_EN != 0) ? INIT : RUN;
            init_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= '0;
        end else begin
            state_q  <= state_d;
            rd_valid <= rd_gnt;
            if (state_q == INIT) init_cnt <= init_cnt + 1'b1;
            if (|wr_gnt) wr_ptr <= next_ptr(wr_win);
            if (|rd_gnt) rd_ptr <= next_ptr(rd_win);
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && init_cnt == '1) state_d = RUN;
    end

    // Outputs are forced idle while rst is low so nothing reaches the SRAM during reset.
    always_comb begin
        wr_gnt   = '0;
        rd_gnt   = '0;
        mem_ce0  = 1'b0;
        mem_we0  = 1'b0;
        mem_a0   = '0;
        mem_d0   = '0;
        mem_wem0 = '0;
        mem_ce1  = 1'b0;
        mem_a1   = '0;
        if (rst) begin
            if (state_q == INIT) begin
                mem_ce0  = 1'b1;
                mem_we0  = 1'b1;
                mem_a0   = init_cnt;
                mem_wem0 = '1;
            end else begin
                if (wr_any) begin
                    wr_gnt   = wr_arb_gnt;
                    mem_ce0  = 1'b1;
                    mem_we0  = 1'b1;
                    mem_a0   = wr_addr_sel;
                    mem_d0   = wr_data[int'(wr_win)*DBITS +: DBITS];
                    mem_wem0 = wr_wem[int'(wr_win)*DBITS +: DBITS];
                end
                if (rd_any && !hazard) begin
                    rd_gnt  = rd_arb_gnt;
                    mem_ce1 = 1'b1;
                    mem_a1  = rd_addr_sel;
                end
            end
        end
    end

    assign init_done = (state_q == RUN);
    assign rd_data   = mem_q1;

endmodule

// File: tb/tb_sram_b_port_arbiter.sv
// Bench for sram_b_port_arbiter with ABITS=4: fill/reset sequences, then a
// vector table in RUN with a read-response scoreboard and a reference memory.
module tb_sram_b_port_arbiter;

    localparam int ABITS = 4;
    localparam int DBITS = 8;
    localparam int NREQ  = 2;

    logic                  CLK;
    logic                  rst;
    logic [NREQ-1:0]       wr_req;
    logic [NREQ*ABITS-1:0] wr_addr;
    logic [NREQ*DBITS-1:0] wr_data;
    logic [NREQ*DBITS-1:0] wr_wem;
    logic [NREQ-1:0]       wr_gnt;
    logic [NREQ-1:0]       rd_req;
    logic [NREQ*ABITS-1:0] rd_addr;
    logic [NREQ-1:0]       rd_gnt;
    logic [NREQ-1:0]       rd_valid;
    logic [DBITS-1:0]      rd_data;
    logic                  init_done;
    logic                  mem_ce0, mem_we0, mem_ce1;
    logic [ABITS-1:0]      mem_a0, mem_a1;
    logic [DBITS-1:0]      mem_d0, mem_wem0, mem_q1;

    typedef struct {
        logic [1:0] wreq;
        logic [3:0] wa0;
        logic [7:0] wd0;
        logic [7:0] wm0;
        logic [3:0] wa1;
        logic [7:0] wd1;
        logic [7:0] wm1;
        logic [1:0] rreq;
        logic [3:0] ra0;
        logic [3:0] ra1;
        logic [1:0] ewg;
        logic [1:0] erg;
    } vec_t;

    typedef struct {
        logic [1:0] valid;
        logic [7:0] data;
    } resp_t;

    vec_t       vecs[16];
    resp_t      sb_q[$];
    logic [7:0] ref_mem[16];
    logic [7:0] sram[16];
    int         n_checks = 0;
    int         n_errors = 0;

    sram_b_port_arbiter #(.ABITS(ABITS), .DBITS(DBITS), .NREQ(NREQ), .INIT_EN(1)) dut (
        .CLK       (CLK),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_wem    (wr_wem),
        .wr_gnt    (wr_gnt),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .init_done (init_done),
        .mem_ce0   (mem_ce0),
        .mem_we0   (mem_we0),
        .mem_a0    (mem_a0),
        .mem_d0    (mem_d0),
        .mem_wem0  (mem_wem0),
        .mem_ce1   (mem_ce1),
        .mem_a1    (mem_a1),
        .mem_q1    (mem_q1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SRAM model: scrambled contents while in reset so the zero-fill is observable.
    always @(posedge CLK) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) sram[i] <= 8'($urandom_range(1, 255));
        end else begin
            if (mem_ce0 && mem_we0) sram[mem_a0] <= (sram[mem_a0] & ~mem_wem0) | (mem_d0 & mem_wem0);
            if (mem_ce1) mem_q1 <= sram[mem_a1];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int n);
        resp_t      exp_resp;
        logic [3:0] exp_a0, exp_a1;
        @(negedge CLK);
        wr_req  = v.wreq;
        wr_addr = {v.wa1, v.wa0};
        wr_data = {v.wd1, v.wd0};
        wr_wem  = {v.wm1, v.wm0};
        rd_req  = v.rreq;
        rd_addr = {v.ra1, v.ra0};
        #1;
        if (sb_q.size() > 0) begin
            exp_resp = sb_q.pop_front();
            checkOutput($sformatf("rd_valid v%0d", n), 32'(rd_valid), 32'(exp_resp.valid));
            checkOutput($sformatf("rd_data v%0d", n), 32'(rd_data), 32'(exp_resp.data));
        end else begin
            checkOutput($sformatf("rd_valid idle v%0d", n), 32'(rd_valid), 32'(0));
        end
        exp_a0 = v.ewg[1] ? v.wa1 : (v.ewg[0] ? v.wa0 : 4'd0);
        exp_a1 = v.erg[1] ? v.ra1 : (v.erg[0] ? v.ra0 : 4'd0);
        checkOutput($sformatf("wr_gnt v%0d", n), 32'(wr_gnt), 32'(v.ewg));
        checkOutput($sformatf("rd_gnt v%0d", n), 32'(rd_gnt), 32'(v.erg));
        checkOutput($sformatf("mem_we0 v%0d", n), 32'(mem_we0), 32'(|v.ewg));
        checkOutput($sformatf("mem_ce1 v%0d", n), 32'(mem_ce1), 32'(|v.erg));
        checkOutput($sformatf("mem_a0 v%0d", n), 32'(mem_a0), 32'(exp_a0));
        checkOutput($sformatf("mem_a1 v%0d", n), 32'(mem_a1), 32'(exp_a1));
        if (v.erg != 2'b00) begin
            exp_resp.valid = v.erg;
            exp_resp.data  = ref_mem[exp_a1];
            sb_q.push_back(exp_resp);
        end
        if (v.ewg[0]) ref_mem[v.wa0] = (ref_mem[v.wa0] & ~v.wm0) | (v.wd0 & v.wm0);
        if (v.ewg[1]) ref_mem[v.wa1] = (ref_mem[v.wa1] & ~v.wm1) | (v.wd1 & v.wm1);
    endtask

    initial begin
        vecs[0]  = '{2'b11, 4'd1, 8'h11, 8'hFF, 4'd2, 8'hFF, 8'hFF, 2'b00, 4'd0, 4'd0, 2'b01, 2'b00};
        vecs[1]  = '{2'b11, 4'd1, 8'h11, 8'hFF, 4'd2, 8'hFF, 8'hFF, 2'b00, 4'd0, 4'd0, 2'b10, 2'b00};
        vecs[2]  = '{2'b11, 4'd1, 8'h11, 8'hFF, 4'd2, 8'hFF, 8'hFF, 2'b00, 4'd0, 4'd0, 2'b01, 2'b00};
        vecs[3]  = '{2'b11, 4'd1, 8'h11, 8'hFF, 4'd2, 8'hFF, 8'hFF, 2'b00, 4'd0, 4'd0, 2'b10, 2'b00};
        vecs[4]  = '{2'b01, 4'd5, 8'hA5, 8'hFF, 4'd0, 8'h00, 8'h00, 2'b00, 4'd0, 4'd0, 2'b01, 2'b00};
        vecs[5]  = '{2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 2'b10, 4'd0, 4'd5, 2'b00, 2'b10};
        vecs[6]  = '{2'b01, 4'd3, 8'h3C, 8'hFF, 4'd0, 8'h00, 8'h00, 2'b10, 4'd0, 4'd3, 2'b01, 2'b00};
        vecs[7]  = '{2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 2'b10, 4'd0, 4'd3, 2'b00, 2'b10};
        vecs[8]  = '{2'b10, 4'd0, 8'h00, 8'h00, 4'd7, 8'h77, 8'hFF, 2'b01, 4'd9, 4'd0, 2'b10, 2'b01};
        vecs[9]  = '{2'b01, 4'd2, 8'h00, 8'h0F, 4'd0, 8'h00, 8'h00, 2'b00, 4'd0, 4'd0, 2'b01, 2'b00};
        vecs[10] = '{2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 2'b01, 4'd2, 4'd0, 2'b00, 2'b01};
        vecs[11] = '{2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 2'b11, 4'd7, 4'd1, 2'b00, 2'b10};
        vecs[12] = '{2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 2'b11, 4'd7, 4'd1, 2'b00, 2'b01};
        vecs[13] = '{2'b01, 4'd1, 8'h5A, 8'hFF, 4'd0, 8'h00, 8'h00, 2'b11, 4'd4, 4'd1, 2'b01, 2'b00};
        vecs[14] = '{2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 2'b10, 4'd0, 4'd1, 2'b00, 2'b10};
        vecs[15] = '{2'b00, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00};
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;

        rst     = 1'b0;
        wr_req  = '0;
        wr_addr = '0;
        wr_data = '0;
        wr_wem  = '0;
        rd_req  = '0;
        rd_addr = '0;
        repeat (2) @(negedge CLK);
        #1;
        checkOutput("reset init_done", 32'(init_done), 32'(0));
        checkOutput("reset mem_ce0", 32'(mem_ce0), 32'(0));
        checkOutput("reset mem_we0", 32'(mem_we0), 32'(0));
        checkOutput("reset mem_ce1", 32'(mem_ce1), 32'(0));
        checkOutput("reset rd_valid", 32'(rd_valid), 32'(0));
        checkOutput("reset wr_gnt", 32'(wr_gnt), 32'(0));

        // Start a fill and abort it with reset when the counter reaches 7.
        @(negedge CLK);
        rst = 1'b1;
        #1;
        checkOutput("abort fill a0 start", 32'(mem_a0), 32'(0));
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            #1;
            checkOutput($sformatf("abort fill a0 %0d", k), 32'(mem_a0), 32'(k));
        end
        rst = 1'b0;
        #1;
        checkOutput("abort mem_we0", 32'(mem_we0), 32'(0));
        checkOutput("abort mem_ce0", 32'(mem_ce0), 32'(0));
        checkOutput("abort mem_a0", 32'(mem_a0), 32'(0));
        checkOutput("abort init_done", 32'(init_done), 32'(0));

        @(negedge CLK);
        rst    = 1'b1;
        wr_req = 2'b11;
        rd_req = 2'b11;
        #1;
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("fill we0 %0d", i), 32'(mem_we0), 32'(1));
            checkOutput($sformatf("fill a0 %0d", i), 32'(mem_a0), 32'(i));
            checkOutput($sformatf("fill d0 %0d", i), 32'(mem_d0), 32'(0));
            checkOutput($sformatf("fill wem0 %0d", i), 32'(mem_wem0), 32'hFF);
            checkOutput($sformatf("fill gnt %0d", i), 32'({wr_gnt, rd_gnt}), 32'(0));
            checkOutput($sformatf("fill ce1 %0d", i), 32'(mem_ce1), 32'(0));
            checkOutput($sformatf("fill init_done %0d", i), 32'(init_done), 32'(0));
            if (i == 15) begin
                wr_req = '0;
                rd_req = '0;
            end
            @(negedge CLK);
            #1;
        end
        checkOutput("run init_done", 32'(init_done), 32'(1));
        checkOutput("run idle mem_ce0", 32'(mem_ce0), 32'(0));

        for (int n = 0; n < 16; n++) applyStimulus(vecs[n], n);
        checkOutput("scoreboard drained", 32'(sb_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
